// File: rtl/icache_ctrl_if.sv
// icache_ctrl_if: CPU fetch port and block-fill memory port of the icache.
// slave = cache side, master = CPU/memory side.
interface icache_ctrl_if #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 8,
  parameter int MEM_SIZE   = 32
);
  localparam int OFF = $clog2(BLOCK_SIZE);
  localparam int BA  = $clog2(MEM_SIZE);
  localparam int AW  = BA + OFF + 2;
  localparam int LW  = WORD_SIZE * BLOCK_SIZE;

  logic                 cpu_req;
  logic [AW-1:0]        cpu_addr;
  logic                 flush;
  logic                 cpu_ready;
  logic [WORD_SIZE-1:0] cpu_instr;
  logic                 mem_ren;
  logic [BA-1:0]        mem_block_address;
  logic                 mem_ready;
  logic [LW-1:0]        mem_dout;
  logic [15:0]          miss_count;

  modport slave (
    input  cpu_req, cpu_addr, flush,
    input  mem_ready, mem_dout,
    output cpu_ready, cpu_instr,
    output mem_ren, mem_block_address,
    output miss_count
  );

  modport master (
    output cpu_req, cpu_addr, flush,
    output mem_ready, mem_dout,
    input  cpu_ready, cpu_instr,
    input  mem_ren, mem_block_address,
    input  miss_count
  );
endinterface

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache, zero-cycle hits, block fills.
// Ports: clock, reset (async, active-high), bus (icache_ctrl_if.slave).
module icache_ctrl #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 8,
  parameter int MEM_SIZE   = 32,
  parameter int CACHE_SIZE = 4
) (
  input  logic         clock,
  input  logic         reset,
  icache_ctrl_if.slave bus
);
  localparam int OFF = $clog2(BLOCK_SIZE);
  localparam int IDX = $clog2(CACHE_SIZE);
  localparam int BA  = $clog2(MEM_SIZE);
  localparam int AW  = BA + OFF + 2;
  localparam int TAG = BA - IDX;
  localparam int LW  = WORD_SIZE * BLOCK_SIZE;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t          state_q;
  logic [CACHE_SIZE-1:0] valid_q;
  logic [TAG-1:0]  tag_q  [CACHE_SIZE];
  logic [LW-1:0]   data_q [CACHE_SIZE];
  logic            mem_ren_q;
  logic [BA-1:0]   blk_q;
  logic [15:0]     miss_q;

  logic [OFF-1:0]  off;
  logic [IDX-1:0]  idx;
  logic [TAG-1:0]  tag;
  logic            lookup;
  logic            hit;
  logic [IDX-1:0]  fill_idx;
  logic [TAG-1:0]  fill_tag;
  logic            fill;

  assign off = bus.cpu_addr[OFF+1:2];
  assign idx = bus.cpu_addr[OFF+IDX+1:OFF+2];
  assign tag = bus.cpu_addr[AW-1:OFF+IDX+2];

  assign lookup = valid_q[idx] && (tag_q[idx] == tag);

  // flush wins over a hit in the same cycle
  assign hit = (state_q == IDLE) && bus.cpu_req
            && !bus.flush && lookup;

  assign bus.cpu_ready = hit;
  assign bus.cpu_instr = hit
    ? data_q[idx][off*WORD_SIZE +: WORD_SIZE]
    : '0;

  assign bus.mem_ren           = mem_ren_q;
  assign bus.mem_block_address = blk_q;
  assign bus.miss_count        = miss_q;

  assign fill_idx = blk_q[IDX-1:0];
  assign fill_tag = blk_q[BA-1:IDX];
  assign fill     = (state_q == REQ) && bus.mem_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      valid_q   <= '0;
      mem_ren_q <= 1'b0;
      blk_q     <= '0;
      miss_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.flush) begin
            valid_q <= '0;
          end else if (bus.cpu_req && !lookup) begin
            blk_q     <= {tag, idx};
            mem_ren_q <= 1'b1;
            state_q   <= REQ;
            if (miss_q != 16'hFFFF)
              miss_q <= miss_q + 16'd1;
          end
        end
        REQ: begin
          if (bus.mem_ready) begin
            valid_q[fill_idx] <= 1'b1;
            mem_ren_q         <= 1'b0;
            state_q           <= RELEASE;
          end
        end
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage has no reset; a fill only happens in REQ, which reset
  // leaves immediately, so an aborted miss never writes a line.
  always_ff @(posedge clock) begin
    if (fill) begin
      data_q[fill_idx] <= bus.mem_dout;
      tag_q[fill_idx]  <= fill_tag;
    end
  end
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed + randomized checks of icache_ctrl against a
// block-residency model of a direct-mapped cache and a latency memory.
module tb_icache_ctrl;
  localparam int WS  = 32;
  localparam int BS  = 8;
  localparam int MS  = 32;
  localparam int CS  = 4;
  localparam int OFF = $clog2(BS);
  localparam int BA  = $clog2(MS);
  localparam int AW  = BA + OFF + 2;
  localparam int LW  = WS * BS;

  logic clock;
  logic reset;

  icache_ctrl_if #(.WORD_SIZE(WS), .BLOCK_SIZE(BS), .MEM_SIZE(MS)) bus ();

  icache_ctrl #(
    .WORD_SIZE(WS), .BLOCK_SIZE(BS),
    .MEM_SIZE(MS), .CACHE_SIZE(CS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [WS-1:0] mem_words [MS][BS];
  int  mem_lat   = 16;
  bit  mem_noise = 0;
  int  mcnt      = 0;

  bit  res_v   [CS];
  int  res_blk [CS];
  int  misses  = 0;

  function automatic logic [LW-1:0] block_data(input int b);
    logic [LW-1:0] d;
    d = '0;
    for (int w = 0; w < BS; w++)
      d[w*WS +: WS] = mem_words[b][w];
    return d;
  endfunction

  function automatic logic [AW-1:0] mk_addr(input int b, input int o);
    int a;
    a = b * BS * 4 + o * 4 + int'($urandom % 4);
    return AW'(a);
  endfunction

  function automatic bit model_hit(input int b);
    return res_v[b % CS] && (res_blk[b % CS] == b);
  endfunction

  task automatic model_fill(input int b);
    res_v[b % CS]   = 1'b1;
    res_blk[b % CS] = b;
    if (misses < 65535) misses++;
  endtask

  task automatic model_clear(input bit cnt);
    for (int i = 0; i < CS; i++) res_v[i] = 1'b0;
    if (cnt) misses = 0;
  endtask

  // Memory: answers mem_ren after mem_lat REQ cycles; optional noise on
  // mem_ready/mem_dout while no request is outstanding.
  always @(negedge clock) begin
    if (bus.mem_ren) begin
      mcnt = mcnt + 1;
      if (mcnt >= mem_lat) begin
        bus.mem_ready = 1'b1;
        bus.mem_dout  = block_data(int'(bus.mem_block_address));
      end else begin
        bus.mem_ready = 1'b0;
      end
    end else begin
      mcnt = 0;
      if (mem_noise) begin
        bus.mem_ready = 1'($urandom % 2);
        for (int w = 0; w < BS; w++)
          bus.mem_dout[w*WS +: WS] = $urandom;
      end else begin
        bus.mem_ready = 1'b0;
      end
    end
  end

  // Drive one fetch and record what the cache did.
  task automatic fetch(
    input  logic [AW-1:0] a,
    input  bit            hold,
    output bit            hit0,
    output bit            ren_seen,
    output logic [BA-1:0] blk,
    output bit            blk_stable,
    output bit            rdy_in_fill,
    output int            rel,
    output logic [WS-1:0] instr,
    output bit            tmo
  );
    bit done;
    hit0 = 0; ren_seen = 0; blk = '0; blk_stable = 1;
    rdy_in_fill = 0; rel = 0; instr = '0; tmo = 0; done = 0;
    @(negedge clock);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    #1;
    if (bus.cpu_ready) begin
      hit0  = 1;
      instr = bus.cpu_instr;
      ren_seen = bus.mem_ren;
      bus.cpu_req = 1'b0;
      return;
    end
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clock);
      #1;
      if (bus.mem_ren) begin
        if (ren_seen && bus.mem_block_address !== blk) blk_stable = 0;
        if (!ren_seen) blk = bus.mem_block_address;
        ren_seen = 1;
        if (bus.cpu_ready) rdy_in_fill = 1;
        if (!hold) begin
          bus.cpu_req  = 1'b0;
          bus.cpu_addr = AW'($urandom);
        end
      end else if (ren_seen) begin
        if (hold && bus.cpu_ready) begin
          instr = bus.cpu_instr;
          done  = 1;
        end else begin
          rel++;
          if (!hold && rel == 1) done = 1;
        end
      end
    end
    if (!done) tmo = 1;
    bus.cpu_req = 1'b0;
  endtask

  bit            h0, rs, bst, rif, tmo;
  logic [BA-1:0] blk;
  int            rel;
  logic [WS-1:0] ins;

  task automatic test_reset();
    reset = 1'b1;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = '0;
    bus.flush    = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    total++;
    if (bus.mem_ren !== 1'b0) begin
      bad++; $display("FAIL reset_ren got=%b exp=0", bus.mem_ren);
    end
    total++;
    if (bus.mem_block_address !== '0) begin
      bad++; $display("FAIL reset_blk got=%0d exp=0", bus.mem_block_address);
    end
    total++;
    if (bus.miss_count !== 16'd0) begin
      bad++; $display("FAIL reset_miss got=%0d exp=0", bus.miss_count);
    end
    total++;
    if (bus.cpu_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%b exp=0", bus.cpu_ready);
    end
    total++;
    if (bus.cpu_instr !== '0) begin
      bad++; $display("FAIL reset_instr got=%h exp=0", bus.cpu_instr);
    end
    bus.cpu_req = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    model_clear(1);
  endtask

  task automatic test_cold_miss();
    mem_lat = 16;
    fetch(AW'(0), 1, h0, rs, blk, bst, rif, rel, ins, tmo);
    model_fill(0);
    total++;
    if (h0 || !rs || tmo) begin
      bad++; $display("FAIL cold_miss hit0=%b ren=%b tmo=%b exp 0 1 0", h0, rs, tmo);
    end
    total++;
    if (blk !== BA'(0) || !bst) begin
      bad++; $display("FAIL cold_blk got=%0d stable=%b exp=0", blk, bst);
    end
    total++;
    if (rif || rel != 1) begin
      bad++; $display("FAIL cold_release ready_in_fill=%b rel=%0d exp 0 1", rif, rel);
    end
    total++;
    if (ins !== mem_words[0][0]) begin
      bad++; $display("FAIL cold_instr got=%h exp=%h", ins, mem_words[0][0]);
    end
    total++;
    if (bus.miss_count !== 16'(misses)) begin
      bad++; $display("FAIL cold_count got=%0d exp=%0d", bus.miss_count, misses);
    end
  endtask

  task automatic test_hit();
    fetch(AW'(12'h01C), 1, h0, rs, blk, bst, rif, rel, ins, tmo);
    total++;
    if (!h0 || rs) begin
      bad++; $display("FAIL hit_zero_cycle hit0=%b ren=%b exp 1 0", h0, rs);
    end
    total++;
    if (ins !== mem_words[0][7]) begin
      bad++; $display("FAIL hit_instr got=%h exp=%h", ins, mem_words[0][7]);
    end
    total++;
    if (bus.miss_count !== 16'd1) begin
      bad++; $display("FAIL hit_count got=%0d exp=1", bus.miss_count);
    end
  endtask

  task automatic test_conflict();
    mem_lat = 3;
    fetch(AW'(12'h080), 1, h0, rs, blk, bst, rif, rel, ins, tmo);
    model_fill(4);
    total++;
    if (h0 || blk !== BA'(4) || ins !== mem_words[4][0]) begin
      bad++; $display("FAIL conflict_miss hit0=%b blk=%0d instr=%h exp 0 4 %h",
                      h0, blk, ins, mem_words[4][0]);
    end
    fetch(AW'(0), 1, h0, rs, blk, bst, rif, rel, ins, tmo);
    model_fill(0);
    total++;
    if (h0 || !rs || blk !== BA'(0)) begin
      bad++; $display("FAIL conflict_remiss hit0=%b ren=%b blk=%0d exp 0 1 0", h0, rs, blk);
    end
    total++;
    if (bus.miss_count !== 16'd3) begin
      bad++; $display("FAIL conflict_count got=%0d exp=3", bus.miss_count);
    end
  endtask

  task automatic test_flush();
    @(negedge clock);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = AW'(0);
    bus.flush    = 1'b1;
    #1;
    total++;
    if (bus.cpu_ready !== 1'b0) begin
      bad++; $display("FAIL flush_ready got=%b exp=0", bus.cpu_ready);
    end
    @(negedge clock);
    bus.cpu_req = 1'b0;
    bus.flush   = 1'b0;
    model_clear(0);
    #1;
    total++;
    if (bus.mem_ren !== 1'b0 || bus.miss_count !== 16'(misses)) begin
      bad++; $display("FAIL flush_nomiss ren=%b cnt=%0d exp 0 %0d",
                      bus.mem_ren, bus.miss_count, misses);
    end
    fetch(AW'(0), 1, h0, rs, blk, bst, rif, rel, ins, tmo);
    model_fill(0);
    total++;
    if (h0 || !rs || blk !== BA'(0)) begin
      bad++; $display("FAIL flush_remiss hit0=%b ren=%b blk=%0d exp 0 1 0", h0, rs, blk);
    end
  endtask

  task automatic test_reset_mid_miss();
    bit seen;
    seen = 0;
    mem_lat = 60;
    @(negedge clock);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = mk_addr(2, 3);
    for (int c = 0; c < 5 && !seen; c++) begin
      @(negedge clock);
      #1;
      seen = bus.mem_ren;
    end
    total++;
    if (!seen) begin
      bad++; $display("FAIL midreset_start ren=%b exp=1", bus.mem_ren);
    end
    bus.cpu_req = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (bus.mem_ren !== 1'b0 || bus.miss_count !== 16'd0) begin
      bad++; $display("FAIL midreset_async ren=%b cnt=%0d exp 0 0",
                      bus.mem_ren, bus.miss_count);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_clear(1);
    mem_lat = 2;
    fetch(AW'(0), 1, h0, rs, blk, bst, rif, rel, ins, tmo);
    model_fill(0);
    total++;
    if (h0 || !rs || blk !== BA'(0) || bus.miss_count !== 16'd1) begin
      bad++; $display("FAIL midreset_retry hit0=%b ren=%b blk=%0d cnt=%0d exp 0 1 0 1",
                      h0, rs, blk, bus.miss_count);
    end
  endtask

  task automatic test_dropped_req();
    mem_lat = 4;
    fetch(mk_addr(9, 2), 0, h0, rs, blk, bst, rif, rel, ins, tmo);
    model_fill(9);
    total++;
    if (h0 || !rs || tmo || blk !== BA'(9) || !bst) begin
      bad++; $display("FAIL drop_fill ren=%b tmo=%b blk=%0d stable=%b exp 1 0 9 1",
                      rs, tmo, blk, bst);
    end
    fetch(mk_addr(9, 5), 1, h0, rs, blk, bst, rif, rel, ins, tmo);
    total++;
    if (!h0 || rs || ins !== mem_words[9][5]) begin
      bad++; $display("FAIL drop_rehit hit0=%b ren=%b instr=%h exp 1 0 %h",
                      h0, rs, ins, mem_words[9][5]);
    end
  endtask

  task automatic test_random();
    int b, o;
    bit eh;
    mem_noise = 1;
    for (int n = 0; n < 80; n++) begin
      if ($urandom % 10 == 0) begin
        @(negedge clock);
        bus.flush    = 1'b1;
        bus.cpu_req  = 1'($urandom % 2);
        bus.cpu_addr = AW'($urandom);
        #1;
        total++;
        if (bus.cpu_ready !== 1'b0) begin
          bad++; $display("FAIL rnd_flush_ready n=%0d got=%b exp=0", n, bus.cpu_ready);
        end
        @(negedge clock);
        bus.flush   = 1'b0;
        bus.cpu_req = 1'b0;
        model_clear(0);
      end
      b = int'($urandom % 12);
      o = int'($urandom % BS);
      mem_lat = int'($urandom_range(1, 5));
      eh = model_hit(b);
      fetch(mk_addr(b, o), 1, h0, rs, blk, bst, rif, rel, ins, tmo);
      if (!eh) model_fill(b);
      total++;
      if (h0 !== eh || tmo) begin
        bad++; $display("FAIL rnd_hit n=%0d blk=%0d got=%b exp=%b tmo=%b", n, b, h0, eh, tmo);
      end
      total++;
      if (ins !== mem_words[b][o]) begin
        bad++; $display("FAIL rnd_instr n=%0d got=%h exp=%h", n, ins, mem_words[b][o]);
      end
      if (!eh) begin
        total++;
        if (blk !== BA'(b) || !bst || rif || rel != 1) begin
          bad++; $display("FAIL rnd_fill n=%0d blk=%0d stable=%b rif=%b rel=%0d exp %0d 1 0 1",
                          n, blk, bst, rif, rel, b);
        end
      end
      total++;
      if (bus.miss_count !== 16'(misses)) begin
        bad++; $display("FAIL rnd_count n=%0d got=%0d exp=%0d", n, bus.miss_count, misses);
      end
    end
    mem_noise = 0;
  endtask

  initial begin
    for (int b = 0; b < MS; b++)
      for (int w = 0; w < BS; w++)
        mem_words[b][w] = $urandom;
    bus.cpu_req   = 1'b0;
    bus.cpu_addr  = '0;
    bus.flush     = 1'b0;
    bus.mem_ready = 1'b0;
    bus.mem_dout  = '0;
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_flush();
    test_reset_mid_miss();
    test_dropped_req();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icache_ctrl.md
ICACHE_CTRL -- requirements
Module: icache_ctrl

Interface
REQ-001 Parameter WORD_SIZE, default 32, instruction/word width in bits.
REQ-002 Parameter BLOCK_SIZE, default 8, words per block (power of two).
REQ-003 Parameter MEM_SIZE, default 32, backing-memory capacity in blocks (power of two).
REQ-004 Parameter CACHE_SIZE, default 4, cache lines (power of two, at most MEM_SIZE).
REQ-005 Derived widths SHALL be OFF = clog2(BLOCK_SIZE), IDX = clog2(CACHE_SIZE), BA = clog2(MEM_SIZE), AW = BA+OFF+2, TAG = BA-IDX.
REQ-006 clock  input  1  sole clock, rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 cpu_req  input  1  fetch request, held by the CPU until cpu_ready.
REQ-009 cpu_addr  input  AW  byte address; bits [1:0] ignored.
REQ-010 flush  input  1  invalidate all lines.
REQ-011 cpu_ready  output  1  fetch complete this cycle.
REQ-012 cpu_instr  output  WORD_SIZE  fetched word.
REQ-013 mem_ren  output  1  block read request to instruction memory.
REQ-014 mem_block_address  output  BA  block address of the fill.
REQ-015 mem_ready  input  1  memory block data valid.
REQ-016 mem_dout  input  WORD_SIZE*BLOCK_SIZE  block data; word 0 in the LSBs.
REQ-017 miss_count  output  16  saturating miss counter.

Function
REQ-018 The cache SHALL be direct-mapped: offset = cpu_addr[OFF+1:2], index = cpu_addr[OFF+IDX+1:OFF+2], tag = cpu_addr[AW-1:OFF+IDX+2].
REQ-019 Storage SHALL be a per-line valid bit, TAG-bit tag and block data; data and tags are not reset.
REQ-020 The FSM SHALL have exactly the states IDLE, REQ and RELEASE.
REQ-021 In IDLE, hit = cpu_req & valid[index] & (tag match); cpu_ready and cpu_instr SHALL be combinational, giving zero-cycle hit latency.
REQ-022 cpu_instr SHALL equal the offset-selected word of the indexed line when cpu_ready=1, and all zeros otherwise.
REQ-023 IDLE with cpu_req, miss and flush=0 SHALL latch {tag,index} into mem_block_address, increment miss_count, and go to REQ at the next edge.
REQ-024 mem_ren SHALL be 1 exactly while in REQ; mem_block_address SHALL stay stable throughout REQ.
REQ-025 In REQ with mem_ready=1, the next edge SHALL write mem_dout into the latched line, write its tag, set its valid bit, and go to RELEASE.
REQ-026 In REQ with mem_ready=0, the block SHALL remain in REQ indefinitely (no timeout).
REQ-027 RELEASE SHALL last exactly one cycle with mem_ren=0, then return to IDLE, so the memory sees ren deasserted between requests.
REQ-028 cpu_ready SHALL be 0 in REQ and RELEASE; the held request hits in the first IDLE cycle after RELEASE.
REQ-029 If cpu_req drops or cpu_addr changes during REQ or RELEASE, the fill SHALL complete for the latched address.
REQ-030 mem_ready outside REQ SHALL be ignored.
REQ-031 flush=1 in IDLE SHALL clear all valid bits at the next edge, force cpu_ready=0 that cycle, and start no miss.
REQ-032 flush in REQ or RELEASE SHALL be ignored; the requester holds flush until IDLE.
REQ-033 miss_count SHALL saturate at 0xFFFF.

Reset
REQ-034 On reset assertion, asynchronously: state=IDLE, all valid bits 0, mem_ren=0, mem_block_address=0, miss_count=0, cpu_ready=0, cpu_instr=0.
REQ-035 Reset asserted mid-miss SHALL abort the fill immediately; no line is written and mem_ren drops without waiting for a clock edge.

Verification
REQ-036 Cold miss: reset, then cpu_req with cpu_addr=0x000 -> mem_ren=1 next cycle with mem_block_address=0; memory model asserts mem_ready after 16 cycles with words W0..W7; one RELEASE cycle, then cpu_ready=1, cpu_instr=W0, miss_count=1.
REQ-037 Hit: next request to cpu_addr=0x01C -> cpu_ready=1 in the same cycle, cpu_instr=W7, mem_ren stays 0, miss_count=1.
REQ-038 Conflict: request 0x080 (block 4, index 0, tag 1) -> miss with mem_block_address=4; then 0x000 misses again -> miss_count=3.
REQ-039 Flush: with line 0 valid, flush=1 for one IDLE cycle -> request to 0x000 misses (mem_ren=1, mem_block_address=0).
REQ-040 Reset mid-miss: reset asserted in REQ -> mem_ren=0 immediately, miss_count=0; retrying 0x000 misses.
REQ-041 Dropped request: cpu_req deasserted during REQ -> fill still completes; a later request to the same block hits with no mem_ren.
